seq_detect_moore_prog: RTL and testbench

SEQ_DETECT_MOORE_PROG -- requirements
Module: seq_detect_moore_prog

---
 rtl/seq_detect_moore_prog.sv | 112 +++++++++++
 tb/tb_seq_detect_moore_prog.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_moore_prog.sv
// rtl/seq_detect_moore_prog.sv - programmable serial pattern detector, Moore output
// Holds a runtime-loadable pattern/length/overlap config and flags each match one cycle later.
module seq_detect_moore_prog #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  localparam int VC_W = $clog2(PAT_W + 1);

  typedef enum logic {SEARCH = 1'b0, DETECT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [VC_W-1:0]    vcnt_q, vcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cfg_err_q, cfg_err_d;

  logic [PAT_W-1:0]   hist_sh;
  logic [VC_W-1:0]    vcnt_sh;
  logic [PAT_W-1:0]   mask;
  logic               len_ok;
  logic               det;

  always_comb begin
    state_d   = SEARCH;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    hist_d    = hist_q;
    vcnt_d    = vcnt_q;
    cnt_d     = cnt_q;
    cfg_err_d = 1'b0;
    det       = 1'b0;

    hist_sh = {hist_q[PAT_W-2:0], x};
    vcnt_sh = (vcnt_q == VC_W'(PAT_W)) ? vcnt_q : vcnt_q + VC_W'(1);
    // Shifting past the width yields zero, so len == PAT_W gives an all-ones mask.
    mask    = ~({PAT_W{1'b1}} << len_q);
    len_ok  = (cfg_len != '0) && (int'(cfg_len) <= PAT_W);

    if (cfg_we) begin
      if (len_ok) begin
        pat_d  = cfg_pat;
        len_d  = cfg_len;
        ovl_d  = cfg_ovl;
        vcnt_d = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (en) begin
      hist_d = hist_sh;
      vcnt_d = vcnt_sh;
      if ((int'(vcnt_sh) >= int'(len_q)) && (((hist_sh ^ pat_q) & mask) == '0)) begin
        det     = 1'b1;
        state_d = DETECT;
        if (!ovl_q) begin
          vcnt_d = '0;
        end
      end
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (det && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEARCH;
      pat_q     <= PAT_W'(10);
      len_q     <= LEN_W'(4);
      ovl_q     <= 1'b1;
      hist_q    <= '0;
      vcnt_q    <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      hist_q    <= hist_d;
      vcnt_q    <= vcnt_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign y         = (state_q == DETECT);
  assign match_cnt = cnt_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_moore_prog.sv
// tb/tb_seq_detect_moore_prog.sv - scoreboard bench for seq_detect_moore_prog
// Directed steps push hand-computed outputs; a negedge monitor pops and compares.
module tb_seq_detect_moore_prog;

  logic       clk;
  logic       rst;
  logic       en;
  logic       x;
  logic       cfg_we;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       cfg_ovl;
  logic       cnt_clr;
  logic       y;
  logic [1:0] match_cnt;
  logic       cfg_err;

  typedef struct packed {
    logic       y;
    logic [1:0] c;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  seq_detect_moore_prog #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .y(y), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic xb, input logic we,
                      input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic clr, input logic ey, input logic [1:0] ec,
                      input logic ee);
    exp_t t;
    @(negedge clk);
    rst = r; en = e; x = xb; cfg_we = we; cfg_pat = p; cfg_len = l;
    cfg_ovl = o; cnt_clr = clr;
    @(posedge clk);
    t.y = ey; t.c = ec; t.e = ee;
    exp_q.push_back(t);
  endtask

  task automatic sb(input logic xb, input logic ey, input logic [1:0] ec);
    step(1'b0, 1'b1, xb, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, ey, ec, 1'b0);
  endtask

  task automatic sb_clr(input logic xb, input logic ey);
    step(1'b0, 1'b1, xb, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, ey, 2'd0, 1'b0);
  endtask

  task automatic idle(input logic [1:0] ec);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, ec, 1'b0);
  endtask

  task automatic clr_idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic do_rst();
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t t;
      t = exp_q.pop_front();
      checks++;
      if (y !== t.y) begin
        errors++;
        $display("FAIL y: got %b expected %b at %0t", y, t.y, $time);
      end
      checks++;
      if (match_cnt !== t.c) begin
        errors++;
        $display("FAIL match_cnt: got %0d expected %0d at %0t", match_cnt, t.c, $time);
      end
      checks++;
      if (cfg_err !== t.e) begin
        errors++;
        $display("FAIL cfg_err: got %b expected %b at %0t", cfg_err, t.e, $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; x = 1'b0; cfg_we = 1'b0; cfg_pat = '0;
    cfg_len = '0; cfg_ovl = 1'b0; cnt_clr = 1'b0;

    // reset (with cfg_we asserted, which reset must override)
    do_rst();

    // overlapping 1010 in 101010
    sb(1'b1, 1'b0, 2'd0);
    sb(1'b0, 1'b0, 2'd0);
    sb(1'b1, 1'b0, 2'd0);
    sb(1'b0, 1'b1, 2'd1);
    sb(1'b1, 1'b0, 2'd1);
    sb(1'b0, 1'b1, 2'd2);
    clr_idle();

    // non-overlapping 1010; config write with en=1 discards x
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    sb(1'b1, 1'b0, 2'd0);
    sb(1'b0, 1'b0, 2'd0);
    sb(1'b1, 1'b0, 2'd0);
    sb(1'b0, 1'b1, 2'd1);
    sb(1'b1, 1'b0, 2'd1);
    sb(1'b0, 1'b0, 2'd1);
    sb(1'b1, 1'b0, 2'd1);
    sb(1'b0, 1'b1, 2'd2);
    clr_idle();

    // full-length pattern with en toggling between bits
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'b1101_1101, 4'd8, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    sb(1'b1, 1'b0, 2'd0); idle(2'd0);
    sb(1'b1, 1'b0, 2'd0); idle(2'd0);
    sb(1'b0, 1'b0, 2'd0); idle(2'd0);
    sb(1'b1, 1'b0, 2'd0); idle(2'd0);
    sb(1'b1, 1'b0, 2'd0); idle(2'd0);
    sb(1'b1, 1'b0, 2'd0); idle(2'd0);
    sb(1'b0, 1'b0, 2'd0); idle(2'd0);
    sb(1'b1, 1'b1, 2'd1); idle(2'd1);

    // illegal lengths 0 and 9 rejected; x in those cycles discarded
    do_rst();
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'd9, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    sb(1'b1, 1'b0, 2'd0);
    sb(1'b0, 1'b0, 2'd0);
    sb(1'b1, 1'b0, 2'd0);
    sb(1'b0, 1'b1, 2'd1);

    // counter saturation at 3, then clear coinciding with a detection
    clr_idle();
    sb(1'b1, 1'b0, 2'd0); sb(1'b0, 1'b1, 2'd1);
    sb(1'b1, 1'b0, 2'd1); sb(1'b0, 1'b1, 2'd2);
    sb(1'b1, 1'b0, 2'd2); sb(1'b0, 1'b1, 2'd3);
    sb(1'b1, 1'b0, 2'd3); sb(1'b0, 1'b1, 2'd3);
    sb(1'b1, 1'b0, 2'd3); sb(1'b0, 1'b1, 2'd3);
    sb(1'b1, 1'b0, 2'd3); sb_clr(1'b0, 1'b1);

    // reset mid-match discards the partial 101
    do_rst();
    sb(1'b1, 1'b0, 2'd0);
    sb(1'b0, 1'b0, 2'd0);
    sb(1'b1, 1'b0, 2'd0);
    do_rst();
    sb(1'b0, 1'b0, 2'd0);
    sb(1'b1, 1'b0, 2'd0);
    sb(1'b0, 1'b0, 2'd0);
    sb(1'b1, 1'b0, 2'd0);
    sb(1'b0, 1'b1, 2'd1);
    idle(2'd1);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
